// File: rtl/cmd_line_exec.sv
`default_nettype none
// ============================================================================
// Module   : cmd_line_exec
// Purpose  : Parses LF-terminated ASCII command lines from a byte stream and
//            executes AAA/BBB/WAIT/DONE on the a/b/done outputs.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_line_exec #(
    parameter int NAME_LEN = 4,
    parameter int PARAM_W  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    output logic [4:0] a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int         NW   = 8 * NAME_LEN;
    localparam int         LW   = $clog2(NAME_LEN + 1);
    localparam logic [7:0] C_SP = 8'h20;
    localparam logic [7:0] C_LF = 8'h0A;
    localparam logic [7:0] C_CR = 8'h0D;

    typedef enum logic [2:0] {
        S_NAME  = 3'd0,
        S_PARAM = 3'd1,
        S_SKIP  = 3'd2,
        S_EXEC  = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [NW-1:0]      name_q, name_d;
    logic [LW-1:0]      len_q, len_d;
    logic [PARAM_W-1:0] acc_q, acc_d;
    logic [PARAM_W-1:0] p0_q, p0_d;
    logic [PARAM_W-1:0] p1_q, p1_d;
    logic [PARAM_W-1:0] cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic               dig_seen_q, dig_seen_d;
    logic               bad_q, bad_d;
    logic [4:0]         a_q, a_d;
    logic               b_q, b_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               w_take;
    logic               w_is_dig;
    logic               w_is_print;
    logic               w_commit;
    logic [31:0]        w_name32;
    logic               w_is_aaa, w_is_bbb, w_is_wait, w_is_done;
    logic               w_known;
    logic               w_empty;

    assign rx_ready   = (state_q == S_NAME) || (state_q == S_PARAM) || (state_q == S_SKIP);
    assign busy       = ~rx_ready;
    assign a          = a_q;
    assign b          = b_q;
    assign done       = done_q;
    assign err        = err_q;

    assign w_take     = rx_valid & rx_ready;
    assign w_is_dig   = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign w_is_print = (rx_data > C_SP) && (rx_data < 8'h7F);

    // Name is shifted in from the right, so the last char sits in the low byte
    assign w_name32   = 32'(name_q);
    assign w_is_aaa   = (int'(len_q) == 3) && (w_name32[23:0] == "AAA");
    assign w_is_bbb   = (int'(len_q) == 3) && (w_name32[23:0] == "BBB");
    assign w_is_wait  = (int'(len_q) == 4) && (w_name32 == "WAIT");
    assign w_is_done  = (int'(len_q) == 4) && (w_name32 == "DONE");
    assign w_known    = w_is_aaa | w_is_bbb | w_is_wait | w_is_done;
    assign w_empty    = (len_q == '0);

    always_comb begin
        state_d    = state_q;
        name_d     = name_q;
        len_d      = len_q;
        acc_d      = acc_q;
        p0_d       = p0_q;
        p1_d       = p1_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        dig_seen_d = dig_seen_q;
        bad_d      = bad_q;
        a_d        = a_q;
        b_d        = b_q;
        done_d     = done_q;
        err_d      = 1'b0;
        w_commit   = 1'b0;

        case (state_q)
            S_NAME: begin
                if (w_take && rx_data != C_CR) begin
                    if (rx_data == C_LF) begin
                        state_d = S_EXEC;
                        err_d   = !w_empty && !w_known;
                    end else if (rx_data == C_SP) begin
                        if (!w_empty) state_d = S_PARAM;
                    end else if (w_is_print && int'(len_q) < NAME_LEN) begin
                        name_d = (name_q << 8) | NW'(rx_data);
                        len_d  = len_q + LW'(1);
                    end else begin
                        bad_d   = 1'b1;
                        state_d = S_SKIP;
                    end
                end
            end
            S_PARAM: begin
                if (w_take && rx_data != C_CR) begin
                    if (rx_data == C_LF) begin
                        w_commit = 1'b1;
                        state_d  = S_EXEC;
                        err_d    = bad_q || !w_known;
                    end else if (w_is_dig) begin
                        acc_d      = acc_q * PARAM_W'(10) + PARAM_W'(rx_data[3:0]);
                        dig_seen_d = 1'b1;
                    end else if (rx_data == C_SP) begin
                        w_commit = 1'b1;
                    end else begin
                        bad_d   = 1'b1;
                        state_d = S_SKIP;
                    end
                end
            end
            S_SKIP: begin
                if (w_take && rx_data == C_LF) begin
                    state_d = S_EXEC;
                    err_d   = 1'b1;
                end
            end
            S_EXEC: begin
                state_d = S_NAME;
                if (!bad_q && w_known) begin
                    if (w_is_aaa) a_d = {1'b0, p0_q[3:0]} + {1'b0, p1_q[3:0]};
                    if (w_is_bbb) b_d = p0_q[0];
                    if (w_is_wait && p0_q != '0) begin
                        cnt_d   = p0_q;
                        state_d = S_WAIT;
                    end
                    if (w_is_done) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
                name_d     = '0;
                len_d      = '0;
                acc_d      = '0;
                p0_d       = '0;
                p1_d       = '0;
                idx_d      = '0;
                dig_seen_d = 1'b0;
                bad_d      = 1'b0;
            end
            S_WAIT: begin
                cnt_d = cnt_q - PARAM_W'(1);
                if (cnt_q == PARAM_W'(1)) state_d = S_NAME;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_NAME;
            end
        endcase

        // A param ends only if it had digits; params past the second are dropped
        if (w_commit && dig_seen_q) begin
            if (idx_q == 2'd0) p0_d = acc_q;
            if (idx_q == 2'd1) p1_d = acc_q;
            if (idx_q != 2'd3) idx_d = idx_q + 2'd1;
            acc_d      = '0;
            dig_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_NAME;
            name_q     <= '0;
            len_q      <= '0;
            acc_q      <= '0;
            p0_q       <= '0;
            p1_q       <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            dig_seen_q <= 1'b0;
            bad_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            name_q     <= name_d;
            len_q      <= len_d;
            acc_q      <= acc_d;
            p0_q       <= p0_d;
            p1_q       <= p1_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            dig_seen_q <= dig_seen_d;
            bad_q      <= bad_d;
            a_q        <= a_d;
            b_q        <= b_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmd_line_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_line_exec
// Purpose  : Self-checking bench for cmd_line_exec using a table of script
//            lines plus directed timing and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_line_exec;

    logic       clk;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [4:0] a;
    logic       b;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;

    cmd_line_exec #(
        .NAME_LEN (4),
        .PARAM_W  (8)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && err) err_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string      txt;
        logic [4:0] exp_a;
        logic       exp_b;
        int         exp_errs;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge
    task automatic send_byte(input logic [7:0] c);
        int t;
        t        = 0;
        rx_valid = 1'b1;
        rx_data  = c;
        while (!rx_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout actual=rx_ready_low required=rx_ready_high");
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int e0;
        int n;

        vecs[0]  = '{"AAA 3 4\n",        5'd7,  1'b0, 0};
        vecs[1]  = '{"AAA 15 15\n",      5'd30, 1'b0, 0};
        vecs[2]  = '{"AAA 300 1\n",      5'd13, 1'b0, 0};
        vecs[3]  = '{"BBB 1\n",          5'd13, 1'b1, 0};
        vecs[4]  = '{"XYZ 2\n",          5'd13, 1'b1, 1};
        vecs[5]  = '{"AAA 3x\n",         5'd13, 1'b1, 1};
        vecs[6]  = '{"ABCDE\n",          5'd13, 1'b1, 1};
        vecs[7]  = '{"\r\n",             5'd13, 1'b1, 0};
        vecs[8]  = '{"BBB 0\n",          5'd13, 1'b0, 0};
        vecs[9]  = '{"  BBB  1 \r\n",    5'd13, 1'b1, 0};
        vecs[10] = '{"AAA 9\n",          5'd9,  1'b1, 0};
        vecs[11] = '{"AAA 1 2 3\n",      5'd3,  1'b1, 0};
        vecs[12] = '{"aaa 1 1\n",        5'd3,  1'b1, 1};
        vecs[13] = '{"AAAA 1 1\n",       5'd3,  1'b1, 1};
        vecs[14] = '{"WAIT 0\n",         5'd3,  1'b1, 0};
        vecs[15] = '{"BBB 2\n",          5'd3,  1'b0, 0};
        vecs[16] = '{"AAA 8 5\n",        5'd13, 1'b0, 0};
        vecs[17] = '{"BB\n",             5'd13, 1'b0, 1};

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick(3);
        rst = 1'b0;

        chk("reset_a",        32'(a), 0);
        chk("reset_b",        32'(b), 0);
        chk("reset_busy",     32'(busy), 0);
        chk("reset_done",     32'(done), 0);
        chk("reset_err",      32'(err), 0);
        chk("reset_rx_ready", 32'(rx_ready), 1);

        for (int i = 0; i < 18; i++) begin
            e0 = err_cnt;
            send_str(vecs[i].txt);
            tick(2);
            chk($sformatf("vec%0d_a", i),    32'(a), 32'(vecs[i].exp_a));
            chk($sformatf("vec%0d_b", i),    32'(b), 32'(vecs[i].exp_b));
            chk($sformatf("vec%0d_err", i),  32'(err_cnt - e0), 32'(vecs[i].exp_errs));
            chk($sformatf("vec%0d_done", i), 32'(done), 0);
        end

        // Result latency: EXEC cycle shows old a, next cycle shows new a
        send_str("AAA 3 4\n");
        chk("exec_rx_ready", 32'(rx_ready), 0);
        chk("exec_busy",     32'(busy), 1);
        chk("exec_a_old",    32'(a), 13);
        tick(1);
        chk("post_exec_a",   32'(a), 7);
        chk("post_exec_rdy", 32'(rx_ready), 1);

        // WAIT 5 stalls for EXEC + 5 cycles
        send_str("BBB 1\n");
        tick(1);
        chk("wait_pre_b", 32'(b), 1);
        send_str("WAIT 5\n");
        n = 0;
        while (!rx_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("wait_stall_clks", 32'(n), 6);
        chk("wait_b_held",     32'(b), 1);
        send_str("BBB 0\n");
        tick(1);
        chk("wait_post_b", 32'(b), 0);

        // Reset mid-line discards the partial command
        send_str("BBB 1\n");
        tick(1);
        send_str("AAA 9");
        do_reset();
        chk("rst_line_a",     32'(a), 0);
        chk("rst_line_b",     32'(b), 0);
        chk("rst_line_rdy",   32'(rx_ready), 1);
        chk("rst_line_busy",  32'(busy), 0);
        e0 = err_cnt;
        send_str("\n");
        tick(2);
        chk("rst_line_lf_a",   32'(a), 0);
        chk("rst_line_lf_err", 32'(err_cnt - e0), 0);

        // Reset mid-WAIT
        send_str("AAA 5 5\n");
        tick(1);
        chk("pre_wait_a", 32'(a), 10);
        send_str("WAIT 200\n");
        tick(10);
        chk("wait200_rdy", 32'(rx_ready), 0);
        do_reset();
        chk("rst_wait_a",    32'(a), 0);
        chk("rst_wait_rdy",  32'(rx_ready), 1);
        chk("rst_wait_busy", 32'(busy), 0);
        send_str("BBB 1\n");
        tick(1);
        chk("rst_wait_b", 32'(b), 1);

        // DONE is terminal; held bytes are not consumed
        send_str("DONE\n");
        tick(1);
        chk("done_set", 32'(done), 1);
        rx_valid = 1'b1;
        rx_data  = "B";
        tick(20);
        chk("done_rdy",  32'(rx_ready), 0);
        chk("done_busy", 32'(busy), 1);
        chk("done_held", 32'(done), 1);
        do_reset();
        chk("done_cleared", 32'(done), 0);
        chk("done_rst_rdy", 32'(rx_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
